seq_datapath: RTL
=================

// Module: seq_datapath
// PURPOSE
//   Parametrised successor to the single-bus CPU datapath: register file, A (operand) and G (result)
//   registers, ALU and shared bus, now with an internal multi-step sequencer and a run/done handshake.
//   The bus is a one-hot-selected mux (no tri-states), so the block is synthesisable on any fabric.
//   It sits between instruction fetch (drives run + fields) and the top level, which observes bus/flags.
// PARAMETERS
//   DATA_W   16  width of bus, registers, A, G, immediate
//   NREGS    8   general registers R0..R(NREGS-1); 2..32
//   RIDX_W   $clog2(NREGS)  localparam, register-index width
// PORTS
//   clk      in   1       rising-edge clock
//   rst_n    in   1       asynchronous active-low reset
//   run      in   1       instruction valid; accepted only when ready=1
//   op       in   3       opcode (encodings in cpu_pkg)
//   rx       in   RIDX_W  destination / first operand index
//   ry       in   RIDX_W  second operand index
//   imm      in   DATA_W  immediate for MVI
//   ready    out  1       high in IDLE; instruction may be accepted this cycle
//   done     out  1       one-cycle pulse: previous instruction has retired
//   bus      out  DATA_W  current bus value (0 when nothing drives it)
//   flag_z   out  1       last ALU result == 0
//   flag_c   out  1       ADD carry-out / SUB borrow of last ADD/SUB
//   dbg_sel  in   RIDX_W  debug read index
//   dbg_data out  DATA_W  combinational R[dbg_sel]; 0 if dbg_sel >= NREGS
// BEHAVIOUR
//   - Reset (async, any state): all Rn, A, G, IR = 0; state IDLE; ready=1, done=0, flags=0, bus=0.
//   - Opcodes: 000 MV Rx<-Ry; 001 MVI Rx<-imm; 010 ADD; 011 SUB (Rx-Ry); 100 AND; 101 OR; 110 XOR;
//     111 NOT Rx<-~Rx (ry ignored). ALU ops: Rx <- Rx op Ry.
//   - FSM: IDLE -> T1 -> (IDLE | T2) ; T2 -> T3 -> IDLE.
//     IDLE: run&&ready latches {op,rx,ry,imm} into IR at the edge; move to T1.
//     T1 MV/MVI: bus=R[ry]/imm, write Rx at edge -> IDLE. T1 ALU: bus=R[rx], A<-bus -> T2.
//     T2: bus=R[ry] (NOT: bus unused), G<-ALU(A,bus), flags updated at edge -> T3.
//     T3: bus=G, Rx<-bus -> IDLE.
//   - done is registered: high for exactly the first IDLE cycle after T1(MV/MVI) or T3.
//     Latency run-accept edge to done: MV/MVI 2 cycles, ALU ops 4 cycles.
//     run in the done cycle is accepted (back-to-back, no bubble).
//   - run while ready=0 is ignored, never queued; inputs sampled only at the accept edge.
//   - Arithmetic modulo 2^DATA_W. flag_c = carry out of DATA_W-bit add; for SUB = 1 when Rx<Ry unsigned.
//     flag_c unchanged by logic ops/NOT; flag_z updated by every ALU op; MV/MVI touch no flags.
//   - rx==ry legal: ADD R2,R2 doubles R2; SUB Rn,Rn gives 0, flag_z=1, flag_c=0.
//   - rx or ry >= NREGS (non-power-of-2 NREGS): executes as NOP, no write, flags unchanged, done after
//     2 cycles like MV.
//   - Reset asserted mid-instruction aborts it: no done; writes completed before reset are also cleared.
//   - At most one bus source per cycle (one-hot select); bus = 0 in IDLE.
// STRUCTURE
//   - cpu_pkg: op_e opcode enum, state_e {IDLE,T1,T2,T3}, bus-source select constants.
//   - Sub-module alu_n #(DATA_W): combinational, (a,b,op) -> {result, carry}.
//   - Register file, A, G, IR, FSM and bus mux live in seq_datapath.
// TESTING
//   1 Reset mid-ADD (assert rst_n=0 in T2) -> all regs 0, ready=1, no done pulse; dbg_data=0 for all.
//   2 MVI R0,0x1234; MVI R1,0x0001 back-to-back (run held) -> done at +2 and +4; R0=0x1234,R1=0x0001.
//   3 MVI R0,0xFFFF; MVI R1,1; ADD R0,R1 -> R0=0x0000, flag_z=1, flag_c=1, done 4 cycles after accept.
//   4 MVI R2,5; MVI R3,7; SUB R2,R3 -> R2=0xFFFE, flag_c=1, flag_z=0; then AND R2,R3 -> R2=0x0006, flag_c=1.
//   5 run pulsed during T2 of ADD -> ignored; only one done; registers reflect one instruction only.
//   6 NREGS=6: MV R7,R0 -> NOP, done at +2, no register changes; ADD R4,R4 with R4=0x4000 -> 0x8000.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared opcode, state and bus-source definitions for the sequenced datapath.
package cpu_pkg;

  typedef enum logic [2:0] {
    OP_MV  = 3'b000,
    OP_MVI = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b011,
    OP_AND = 3'b100,
    OP_OR  = 3'b101,
    OP_XOR = 3'b110,
    OP_NOT = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    T1   = 2'd1,
    T2   = 2'd2,
    T3   = 2'd3
  } state_e;

  // One-hot bus source selects; all-zero means nothing drives the bus
  localparam logic [2:0] SEL_NONE = 3'b000;
  localparam logic [2:0] SEL_REG  = 3'b001;
  localparam logic [2:0] SEL_IMM  = 3'b010;
  localparam logic [2:0] SEL_G    = 3'b100;

  function automatic logic is_alu(input op_e op);
    return (op != OP_MV) && (op != OP_MVI);
  endfunction

  function automatic logic uses_ry(input op_e op);
    return (op != OP_MVI) && (op != OP_NOT);
  endfunction

endpackage

// File: rtl/alu_n.sv
// Combinational ALU: result and carry/borrow for the opcode held in IR.
module alu_n
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        op,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  // Carry is the extra MSB of a widened add/subtract; for SUB it reads as borrow
  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (op_e'(op))
      OP_ADD:  {carry, result} = {1'b0, a} + {1'b0, b};
      OP_SUB:  {carry, result} = {1'b0, a} - {1'b0, b};
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NOT:  result = ~a;
      default: result = b;
    endcase
  end

endmodule

// File: rtl/seq_datapath.sv
// Single-bus datapath with register file, A/G registers, ALU and a four-state
// sequencer that executes one instruction per run/done handshake.
module seq_datapath
  import cpu_pkg::*;
#(
  parameter  int DATA_W = 16,
  parameter  int NREGS  = 8,
  localparam int RIDX_W = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic [2:0]        op,
  input  logic [RIDX_W-1:0] rx,
  input  logic [RIDX_W-1:0] ry,
  input  logic [DATA_W-1:0] imm,
  output logic              ready,
  output logic              done,
  output logic [DATA_W-1:0] bus,
  output logic              flag_z,
  output logic              flag_c,
  input  logic [RIDX_W-1:0] dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);

  localparam logic [RIDX_W:0] NREGS_L = (RIDX_W + 1)'(NREGS);

  state_e              state;
  op_e                 ir_op;
  logic [RIDX_W-1:0]   ir_rx;
  logic [RIDX_W-1:0]   ir_ry;
  logic [DATA_W-1:0]   ir_imm;
  logic                ir_nop;
  logic [DATA_W-1:0]   regs [NREGS];
  logic [DATA_W-1:0]   a_reg;
  logic [DATA_W-1:0]   g_reg;
  logic [2:0]          bus_sel;
  logic [RIDX_W-1:0]   rd_idx;
  logic [DATA_W-1:0]   rd_val;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_c;

  function automatic logic in_range(input logic [RIDX_W-1:0] idx);
    return {1'b0, idx} < NREGS_L;
  endfunction

  // Bus source and register read index are decoded from state and IR only
  always_comb begin
    bus_sel = SEL_NONE;
    rd_idx  = ir_ry;
    case (state)
      T1: begin
        if (ir_nop) begin
          bus_sel = SEL_NONE;
        end else if (ir_op == OP_MVI) begin
          bus_sel = SEL_IMM;
        end else if (ir_op == OP_MV) begin
          bus_sel = SEL_REG;
        end else begin
          bus_sel = SEL_REG;
          rd_idx  = ir_rx;
        end
      end
      T2: begin
        if (ir_op == OP_NOT) begin
          bus_sel = SEL_NONE;
        end else begin
          bus_sel = SEL_REG;
        end
      end
      T3:      bus_sel = SEL_G;
      default: bus_sel = SEL_NONE;
    endcase
  end

  assign rd_val   = regs[rd_idx];
  assign bus      = ({DATA_W{bus_sel[0]}} & rd_val)
                  | ({DATA_W{bus_sel[1]}} & ir_imm)
                  | ({DATA_W{bus_sel[2]}} & g_reg);
  assign dbg_data = in_range(dbg_sel) ? regs[dbg_sel] : '0;

  alu_n #(.DATA_W(DATA_W)) u_alu (
    .a      (a_reg),
    .b      (bus),
    .op     (ir_op),
    .result (alu_res),
    .carry  (alu_c)
  );

  // Sequencer plus all datapath state; ready/done/flags are registered here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ir_op  <= OP_MV;
      ir_rx  <= '0;
      ir_ry  <= '0;
      ir_imm <= '0;
      ir_nop <= 1'b0;
      a_reg  <= '0;
      g_reg  <= '0;
      ready  <= 1'b1;
      done   <= 1'b0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (run) begin
            ir_op  <= op_e'(op);
            ir_rx  <= rx;
            ir_ry  <= ry;
            ir_imm <= imm;
            // ry only matters for opcodes that actually read it
            ir_nop <= !in_range(rx) || (uses_ry(op_e'(op)) && !in_range(ry));
            state  <= T1;
            ready  <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        T1: begin
          if (ir_nop) begin
            state <= IDLE;
            ready <= 1'b1;
            done  <= 1'b1;
          end else if (!is_alu(ir_op)) begin
            regs[ir_rx] <= bus;
            state       <= IDLE;
            ready       <= 1'b1;
            done        <= 1'b1;
          end else begin
            a_reg <= bus;
            state <= T2;
          end
        end
        T2: begin
          g_reg  <= alu_res;
          flag_z <= (alu_res == '0);
          if ((ir_op == OP_ADD) || (ir_op == OP_SUB)) begin
            flag_c <= alu_c;
          end
          state <= T3;
        end
        T3: begin
          regs[ir_rx] <= bus;
          state       <= IDLE;
          ready       <= 1'b1;
          done        <= 1'b1;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
